ff_gain_mc: RTL and testbench
=============================

# ff_gain_mc

Multi-channel feed-forward gain stage for the FOC current/speed loops. Each channel computes o_value[k] = sat(i_aim[k] × Kg[k] >> SHIFT). The channels share one time-multiplexed multiplier to save DSP slices. A job starts on an i_en pulse; all channel results are presented together with a one-cycle o_en strobe and per-channel saturation flags. The block sits between the setpoint generator and the PI controllers' feed-forward summing input.

## Interface
- N_CH, 2, number of channels (≥1)
- DW, 16, signed aim/result width
- KW, 16, unsigned gain width
- SHIFT, 8, right shift applied to product (Kg = 2^SHIFT is gain 1.0); 1 ≤ SHIFT < DW+KW
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- i_en  in  1  start pulse; sampled only when o_busy=0
- i_aim  in  N_CH*DW  packed signed aims, channel k at [k*DW +: DW]
- i_kg  in  N_CH*KW  packed unsigned gains, same packing
- o_busy  out  1  job in progress
- o_en  out  1  one-cycle result-valid strobe
- o_value  out  N_CH*DW  packed signed results, held until next o_en
- o_sat  out  N_CH  per-channel saturation flag for the last job, updated with o_value

## Operation
- States: IDLE, RUN.
- IDLE: on a rising clk edge with i_en=1:
  - latch i_aim and i_kg into an input buffer;
  - set channel index to 0;
  - set o_busy=1;
  - go to RUN.
- i_en while o_busy=1 is ignored. The buffered inputs are not changed.
- RUN, stage 1: one channel per cycle, index 0..N_CH-1. Product p = aim × $signed({1'b0, kg}), width DW+KW+1.
- RUN, stage 2:
  - r = p >>> SHIFT (arithmetic shift).
  - If r > 2^(DW-1)-1, the result is 2^(DW-1)-1 and the sat bit is 1.
  - If r < -2^(DW-1), the result is -2^(DW-1) and the sat bit is 1.
  - Otherwise the result is r[DW-1:0] and the sat bit is 0.
- Results for channels 0..N_CH-2 go into a shadow register.
- When the last channel leaves stage 2, o_value and o_sat load shadow plus last result in one update. The same edge sets o_en=1, clears o_busy and returns to IDLE.
- o_value never shows a partial job.
- Reset, including reset during RUN: return to IDLE and clear the pipeline. No o_en is emitted for the aborted job.
- Reset values of outputs: o_busy=0, o_en=0, o_value=0, o_sat=0.

## Timing
- Edge E0 samples i_en=1 with o_busy=0.
- Channel k product is registered at E(k+1).
- Channel k result is registered at E(k+2).
- o_en and o_value are updated at E(N_CH+1). o_en is high for exactly the cycle after E(N_CH+1).
- o_busy is high from after E0 through E(N_CH+1).
- The earliest next accepted i_en is at E(N_CH+2). Throughput is one job per N_CH+2 cycles.
- N_CH=1: o_en rises after E2.
- Stage 1 and stage 2 are each one register stage. The multiplier must meet timing at the system clock with no further retiming.

## Configuration
- FFGAIN_ROUND_EN:
  - Defined: add 2^(SHIFT-1) to p before the shift, which is round-half-up toward +∞. Saturation is checked after rounding.
  - Undefined: plain arithmetic shift, which truncates toward −∞.
- Latency is identical in both builds.

## Structure
- Package ff_gain_pkg holds:
  - the default parameter constants;
  - the state enum (IDLE, RUN);
  - localparam helpers for product width and saturation bounds.
- Sub-module ff_gain_lane holds the multiply → round → saturate two-stage pipeline (stage registers and sat flag).
- The top level holds the FSM, channel index counter, input buffer, shadow register and output register.

## Test plan
Default parameters unless stated; expected values are per build where they differ.
- Unity gain. Inputs: N_CH=2, aim={1000,-1000}, kg={256,256}. Response: after E3, o_en pulses once; o_value={1000,-1000}; o_sat=0.
- Half gain. Input: aim=-1000, kg=128. Response: -500 in both builds.
- Saturation.
  - aim=30000, kg=512 → 32767, sat=1.
  - aim=-30000, kg=512 → -32768, sat=1.
- Rounding.
  - aim=3, kg=128: 1 without FFGAIN_ROUND_EN, 2 with it.
  - aim=-3, kg=128: -2 without, -1 with.
- Busy handling.
  - Pulse i_en, then pulse it again during RUN with different inputs. Response: results for the first inputs only; a single o_en.
  - Pulse i_en at E(N_CH+2). Response: accepted.
- Reset mid-job. Assert rstn=0 at E2, release it, wait 10 cycles. Response: no o_en; o_value=0; o_busy=0; the next job runs normally.

Source files
------------

// File: rtl/ff_gain_pkg.sv
// ff_gain_pkg: shared constants, FSM state type and width/bound helpers
// for the ff_gain_mc feed-forward gain stage.
package ff_gain_pkg;

  localparam int N_CH_DEF  = 2;
  localparam int DW_DEF    = 16;
  localparam int KW_DEF    = 16;
  localparam int SHIFT_DEF = 8;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Signed aim times zero-extended unsigned gain.
  function automatic int prod_w(input int dw, input int kw);
    return dw + kw + 1;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/ff_gain_mc_if.sv
// ff_gain_mc_if: job request / result bundle of the feed-forward gain stage.
interface ff_gain_mc_if
  import ff_gain_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DW   = DW_DEF,
  parameter int KW   = KW_DEF
);
  logic                 i_en;
  logic [N_CH*DW-1:0]   i_aim;
  logic [N_CH*KW-1:0]   i_kg;
  logic                 o_busy;
  logic                 o_en;
  logic [N_CH*DW-1:0]   o_value;
  logic [N_CH-1:0]      o_sat;

  modport master (
    output i_en, i_aim, i_kg,
    input  o_busy, o_en, o_value, o_sat
  );

  modport slave (
    input  i_en, i_aim, i_kg,
    output o_busy, o_en, o_value, o_sat
  );
endinterface

// File: rtl/ff_gain_lane.sv
// ff_gain_lane: shared multiplier lane. Stage 1 registers the product;
// stage 2 shifts and saturates it for capture by the top level.
// Build option: define FFGAIN_ROUND_EN for round-half-up before the shift.
module ff_gain_lane
  import ff_gain_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int KW    = KW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int IW    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [IW-1:0]        in_idx,
  input  logic signed [DW-1:0] in_aim,
  input  logic [KW-1:0]        in_kg,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [IW-1:0]        out_idx,
  output logic signed [DW-1:0] out_res,
  output logic                 out_sat
);
  localparam int PW = prod_w(DW, KW);
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] MAXV = RW'(sat_max(DW));
  localparam logic signed [RW-1:0] MINV = RW'(sat_min(DW));
`ifdef FFGAIN_ROUND_EN
  localparam logic signed [RW-1:0] RND  = RW'(longint'(1) <<< (SHIFT - 1));
`endif

  logic signed [PW-1:0] p_q;
  logic                 valid_q;
  logic                 last_q;
  logic [IW-1:0]        idx_q;
  logic signed [RW-1:0] p_ext;
  logic signed [RW-1:0] p_adj;
  logic signed [RW-1:0] r;

  // Stage 1: register the signed product and its channel tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      p_q     <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        last_q <= in_last;
        idx_q  <= in_idx;
        p_q    <= PW'(in_aim) * $signed(PW'({1'b0, in_kg}));
      end
    end
  end

  // Stage 2: optional rounding, arithmetic shift, clamp to DW.
  always_comb begin
    p_ext = RW'(p_q);
`ifdef FFGAIN_ROUND_EN
    p_adj = p_ext + RND;
`else
    p_adj = p_ext;
`endif
    r       = p_adj >>> SHIFT;
    out_res = r[DW-1:0];
    out_sat = 1'b0;
    if (r > MAXV) begin
      out_res = MAXV[DW-1:0];
      out_sat = 1'b1;
    end else if (r < MINV) begin
      out_res = MINV[DW-1:0];
      out_sat = 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_idx   = idx_q;

endmodule

// File: rtl/ff_gain_mc.sv
// ff_gain_mc: multi-channel feed-forward gain, one shared multiplier lane
// time-multiplexed over N_CH channels; all results published together.
// Build option: FFGAIN_ROUND_EN (handled inside ff_gain_lane).
module ff_gain_mc
  import ff_gain_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DW    = DW_DEF,
  parameter int KW    = KW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input logic          clk,
  input logic          rstn,
  ff_gain_mc_if.slave  bus
);
  localparam int IW = $clog2(N_CH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);
  localparam logic [IW-1:0] END_IDX  = IW'(N_CH);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        sel;
  logic [N_CH*DW-1:0]   aim_buf;
  logic [N_CH*KW-1:0]   kg_buf;
  logic [N_CH*DW-1:0]   shadow_val, upd_val;
  logic [N_CH-1:0]      shadow_sat, upd_sat;
  logic                 accept, feed, finish;
  logic signed [DW-1:0] lane_aim;
  logic [KW-1:0]        lane_kg;
  logic                 lane_valid, lane_last, lane_sat;
  logic [IW-1:0]        lane_idx;
  logic signed [DW-1:0] lane_res;

  assign accept = (state_q == IDLE) && bus.i_en;
  assign feed   = (state_q == RUN) && (idx_q != END_IDX);
  assign sel    = feed ? idx_q : '0;
  assign finish = lane_valid && lane_last;
  assign lane_aim = aim_buf[int'(sel)*DW +: DW];
  assign lane_kg  = kg_buf[int'(sel)*KW +: KW];
  assign bus.o_busy = (state_q == RUN);

  ff_gain_lane #(
    .DW    (DW),
    .KW    (KW),
    .SHIFT (SHIFT),
    .IW    (IW)
  ) u_lane (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (feed),
    .in_last   (idx_q == LAST_IDX),
    .in_idx    (sel),
    .in_aim    (lane_aim),
    .in_kg     (lane_kg),
    .out_valid (lane_valid),
    .out_last  (lane_last),
    .out_idx   (lane_idx),
    .out_res   (lane_res),
    .out_sat   (lane_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: start on accepted i_en, finish when the last channel exits stage 2.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.i_en) state_d = RUN;
      RUN:  if (finish)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow with the current stage-2 result merged in; this is both the next
  // shadow value and, for the last channel, the complete published result.
  always_comb begin
    upd_val = shadow_val;
    upd_sat = shadow_sat;
    upd_val[int'(lane_idx)*DW +: DW] = lane_res;
    upd_sat[lane_idx] = lane_sat;
  end

  // Input buffer, channel counter, shadow and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aim_buf     <= '0;
      kg_buf      <= '0;
      idx_q       <= '0;
      shadow_val  <= '0;
      shadow_sat  <= '0;
      bus.o_en    <= 1'b0;
      bus.o_value <= '0;
      bus.o_sat   <= '0;
    end else begin
      if (accept) begin
        aim_buf <= bus.i_aim;
        kg_buf  <= bus.i_kg;
        idx_q   <= '0;
      end else if (feed) begin
        idx_q <= idx_q + 1'b1;
      end
      if (lane_valid) begin
        shadow_val <= upd_val;
        shadow_sat <= upd_sat;
      end
      bus.o_en <= finish;
      if (finish) begin
        bus.o_value <= upd_val;
        bus.o_sat   <= upd_sat;
      end
    end
  end

endmodule

// File: tb/tb_ff_gain_mc.sv
// tb_ff_gain_mc: directed, scoreboard-checked bench for ff_gain_mc.
module tb_ff_gain_mc;
  import ff_gain_pkg::*;

  localparam int N_CH  = 2;
  localparam int DW    = 16;
  localparam int KW    = 16;
  localparam int SHIFT = 8;

  typedef struct {
    logic signed [DW-1:0] val;
    logic                 sat;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   en_count = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ff_gain_mc_if #(.N_CH(N_CH), .DW(DW), .KW(KW)) bus ();

  ff_gain_mc #(.N_CH(N_CH), .DW(DW), .KW(KW), .SHIFT(SHIFT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Count o_en pulses, sampled shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (bus.o_en === 1'b1) en_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input longint aim, input longint kg);
    exp_t   e;
    longint p, r, hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    p  = aim * kg;
`ifdef FFGAIN_ROUND_EN
    p  = p + (longint'(1) <<< (SHIFT - 1));
`endif
    r  = p >>> SHIFT;
    if (r > hi) begin
      e.val = DW'(hi);
      e.sat = 1'b1;
    end else if (r < lo) begin
      e.val = DW'(lo);
      e.sat = 1'b1;
    end else begin
      e.val = DW'(r);
      e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called at a falling edge; i_en is sampled by the next rising edge (E0).
  task automatic drive_job(input int a0, input int k0, input int a1, input int k1,
                           input bit expect_out);
    bus.i_aim = {16'(a1), 16'(a0)};
    bus.i_kg  = {16'(k1), 16'(k0)};
    bus.i_en  = 1'b1;
    if (expect_out) begin
      sb.push_back(model(a0, k0));
      sb.push_back(model(a1, k1));
    end
    @(negedge clk);
    bus.i_en = 1'b0;
    check("start_busy", bus.o_busy, 1);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int   lat  = 0;
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_en === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, "_o_en_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_clear"}, bus.o_busy, 0);
      for (int c = 0; c < N_CH; c++) begin
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 0, 1);
        end else begin
          e = sb.pop_front();
          check($sformatf("%s_val%0d", tag, c), $signed(bus.o_value[c*DW +: DW]), e.val);
          check($sformatf("%s_sat%0d", tag, c), bus.o_sat[c], e.sat);
        end
      end
    end else begin
      sb.delete();
    end
  endtask

  task automatic check_hold(input string tag);
    logic [N_CH*DW-1:0] v;
    v = bus.o_value;
    @(negedge clk);
    check({tag, "_o_en_one_cycle"}, bus.o_en, 0);
    check({tag, "_value_held"}, bus.o_value, v);
  endtask

  initial begin
    int en_before;
    bus.i_en  = 1'b0;
    bus.i_aim = '0;
    bus.i_kg  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  bus.o_busy,  0);
    check("rst_en",    bus.o_en,    0);
    check("rst_value", bus.o_value, 0);
    check("rst_sat",   bus.o_sat,   0);
    rstn = 1'b1;
    @(negedge clk);

    drive_job(1000, 256, -1000, 256, 1);
    wait_result("unity", N_CH + 1);
    check_hold("unity");

    drive_job(-1000, 128, 7, 300, 1);
    wait_result("half", N_CH + 1);
    check_hold("half");

    drive_job(30000, 512, -30000, 512, 1);
    wait_result("sat", N_CH + 1);
    check_hold("sat");

    drive_job(3, 128, -3, 128, 1);
    wait_result("round", N_CH + 1);
    check_hold("round");

    // Second pulse during RUN must be ignored; then restart at E(N_CH+2).
    en_before = en_count;
    drive_job(500, 256, -700, 384, 1);
    bus.i_aim = {16'(123), 16'(-456)};
    bus.i_kg  = {16'(999), 16'(777)};
    bus.i_en  = 1'b1;
    @(negedge clk);
    bus.i_en  = 1'b0;
    wait_result("busy_ignore", N_CH);
    drive_job(-32768, 65535, 32767, 1, 1);
    wait_result("back2back", N_CH + 1);
    check_hold("back2back");
    check("busy_en_pulses", en_count - en_before, 2);

    // Reset in the middle of a job.
    drive_job(1234, 256, -1234, 256, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    en_before = en_count;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_en",  en_count - en_before, 0);
    check("abort_value",  bus.o_value, 0);
    check("abort_sat",    bus.o_sat,   0);
    check("abort_busy",   bus.o_busy,  0);

    drive_job(-200, 1024, 50, 1, 1);
    wait_result("after_rst", N_CH + 1);
    check_hold("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
